input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//  Upstream conditioning stage for the level-sensitive D-latch datapath.
//  Takes a raw, bouncy, asynchronous input (switch or push-button). Synchronises it
//  to clk, filters bounce with a counter-based FSM, and emits:
//  - a clean data level (d_out), which drives the latch D input;
//  - a one-cycle strobe (en_out), which drives the latch En input.
//  The latch therefore only ever sees stable, glitch-free D/En.
// PARAMETERS
//  SYNC_STAGES    2  synchroniser flip-flop depth; legal range >=2
//  STABLE_CYCLES  4  consecutive identical synchronised samples needed to accept a new level; >=2
//  CNT_W          3  debounce counter width; must satisfy 2**CNT_W > STABLE_CYCLES
// PORTS
//  clk     input   1  single system clock; all state updates on the rising edge
//  rst     input   1  synchronous, active-high reset
//  din     input   1  raw asynchronous input
//  d_out   output  1  debounced level (registered)
//  en_out  output  1  one-cycle pulse on any accepted level change (registered)
//  rise    output  1  one-cycle pulse when the accepted level goes 0->1
//  fall    output  1  one-cycle pulse when the accepted level goes 1->0
//  busy    output  1  high while a candidate level change is being qualified
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, in any state or mid-count):
//  - sync chain = 0, state = LOW_STABLE, cnt = 0;
//  - d_out = en_out = rise = fall = busy = 0 after that edge;
//  - rst overrides din for as long as it is held.
//  Synchroniser: s = last stage of the SYNC_STAGES-deep chain. din affects only the first stage.
//  FSM (4 states):
//  - LOW_STABLE: s=1 -> WAIT_HIGH, cnt=1; otherwise stay.
//  - WAIT_HIGH:
//    - s=0 -> LOW_STABLE, cnt=0 (glitch rejected, no pulse);
//    - s=1 and cnt==STABLE_CYCLES-1 -> HIGH_STABLE; d_out<=1, en_out<=1, rise<=1 for one cycle;
//    - otherwise cnt<=cnt+1.
//  - HIGH_STABLE: s=0 -> WAIT_LOW, cnt=1; otherwise stay.
//  - WAIT_LOW: mirror of WAIT_HIGH; on acceptance d_out<=0, en_out<=1, fall<=1.
//  busy = 1 exactly while in WAIT_HIGH or WAIT_LOW (registered with the state).
//  Latency: din step held stable -> d_out and en_out change SYNC_STAGES+STABLE_CYCLES edges later
//  (6 at defaults).
//  Pulses: en_out/rise/fall are high for exactly one cycle per accepted edge. rise and fall are
//  never both high. en_out = rise|fall.
//  Counter never wraps: it is cleared on every return to a stable state; max value is
//  STABLE_CYCLES-1.
//  Input toggling faster than STABLE_CYCLES samples: d_out frozen, no pulses, busy toggles.
//  Stuck-at input: no repeated pulses; the stable states hold indefinitely.
// STRUCTURE
//  Shared package debounce_pkg:
//  - state encoding localparams LOW_STABLE=2'b00, WAIT_HIGH=2'b01, HIGH_STABLE=2'b10, WAIT_LOW=2'b11;
//  - default STABLE_CYCLES constant.
//  One sub-module, sync_chain:
//  - parameterised SYNC_STAGES shift register with synchronous reset;
//  - reusable by other input stages.
//  Top level holds the FSM, counter and output registers.
// TESTING
//  1 Reset: rst=1 for 2 cycles with din=1 -> all outputs 0; after release, d_out rises at edge 6.
//  2 Clean step: din 0->1 held 10 cycles -> d_out=1 and rise=en_out=1 exactly 6 edges later,
//    pulse 1 cycle wide; fall stays 0.
//  3 Bounce: din pattern 1,0,1,1,0 at 1-cycle spacing, then held 1 -> no pulse during bounce;
//    a single rise pulse 6 edges after the final 0->1.
//  4 Glitch reject: din=1 held for 3 cycles then 0 -> d_out stays 0, no pulses, busy high 3 cycles.
//  5 Falling edge from HIGH_STABLE: din 1->0 held -> fall=en_out=1 for one cycle, d_out=0 at +6 edges.
//  6 Reset mid-qualify: assert rst while busy=1 (cnt=2) -> next edge busy=0, state LOW_STABLE,
//    no pulse emitted.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and default sizing.
// Other input-conditioning stages can reuse these constants.
package debounce_pkg;

  typedef logic [1:0] state_t;

  localparam state_t LOW_STABLE  = 2'b00;
  localparam state_t WAIT_HIGH   = 2'b01;
  localparam state_t HIGH_STABLE = 2'b10;
  localparam state_t WAIT_LOW    = 2'b11;

  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_STABLE_CYCLES = 4;
  localparam int DEFAULT_CNT_W         = 3;

  // True while a candidate level change is being qualified.
  function automatic logic is_qualifying(input state_t st);
    return (st == WAIT_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input bit.
// The raw input touches only the first flop; dout is the last stage.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises a bouncy input and accepts a new level only after STABLE_CYCLES
// identical samples, producing a clean level plus one-cycle change strobes.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic d_out,
  output logic en_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_out_q, d_out_d;
  logic             en_q, en_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter is cleared on every return to a stable state, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOW_STABLE: begin
        cnt_d = '0;
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        cnt_d = '0;
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rise_d  = (state_q == WAIT_HIGH) && s && (cnt_q == CNT_LAST);
    fall_d  = (state_q == WAIT_LOW) && !s && (cnt_q == CNT_LAST);
    en_d    = rise_d | fall_d;
    d_out_d = d_out_q;
    if (rise_d) begin
      d_out_d = 1'b1;
    end else if (fall_d) begin
      d_out_d = 1'b0;
    end
    busy_d  = is_qualifying(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q <= 1'b0;
      en_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      d_out_q <= d_out_d;
      en_q    <= en_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign d_out  = d_out_q;
  assign en_out = en_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer; observed vector is {d_out,en_out,rise,fall,busy}.
module tb_input_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic d_out, en_out, rise, fall, busy;

  int n_tests = 0;
  int n_fail  = 0;

  bit bounce_din  [16] = '{1,0,1,1,0,1,1,1,1,1,1,1,1,1,1,1};
  bit bounce_busy [16] = '{0,0,1,0,1,1,0,1,1,1,0,0,0,0,0,0};

  input_debouncer dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .d_out  (d_out),
    .en_out (en_out),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] exp_v;
    logic [4:0] obs;
    rst = 1'b1;
    din = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      obs = {d_out, en_out, rise, fall, busy};
      n_tests++;
      if (obs !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", k, obs, 5'b00000);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = {k >= 6, k == 6, k == 6, 1'b0, (k >= 3 && k <= 5)};
      obs = {d_out, en_out, rise, fall, busy};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_fall();
    logic [4:0] exp_v;
    logic [4:0] obs;
    din = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_v = {k < 6, k == 6, 1'b0, k == 6, (k >= 3 && k <= 5)};
      obs = {d_out, en_out, rise, fall, busy};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL fall_step cyc=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  // Held high well past acceptance: exactly one rise, then the stable state holds.
  task automatic test_clean_step();
    logic [4:0] exp_v;
    logic [4:0] obs;
    din = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_v = {k >= 6, k == 6, k == 6, 1'b0, (k >= 3 && k <= 5)};
      obs = {d_out, en_out, rise, fall, busy};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL clean_step cyc=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] exp_v;
    logic [4:0] obs;
    for (int k = 1; k <= 16; k++) begin
      din = bounce_din[k-1];
      tick();
      exp_v = {k >= 11, k == 11, k == 11, 1'b0, bounce_busy[k-1]};
      obs = {d_out, en_out, rise, fall, busy};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL bounce cyc=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_glitch_reject();
    logic [4:0] exp_v;
    logic [4:0] obs;
    for (int k = 1; k <= 10; k++) begin
      din = (k <= 3);
      tick();
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, (k >= 3 && k <= 5)};
      obs = {d_out, en_out, rise, fall, busy};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL glitch_reject cyc=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_qualify();
    logic [4:0] exp_v;
    logic [4:0] obs;
    din = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, k >= 3};
      obs = {d_out, en_out, rise, fall, busy};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL midq_approach cyc=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
    rst = 1'b1;
    tick();
    obs = {d_out, en_out, rise, fall, busy};
    n_tests++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL midq_reset got=%b want=%b", obs, 5'b00000);
    end
    rst = 1'b0;
    din = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      obs = {d_out, en_out, rise, fall, busy};
      n_tests++;
      if (obs !== 5'b00000) begin
        n_fail++;
        $display("FAIL midq_after cyc=%0d got=%b want=%b", k, obs, 5'b00000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_clean_step();
    test_fall();
    test_bounce();
    test_fall();
    test_glitch_reject();
    test_reset_mid_qualify();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
